// File: rtl/time_counter.sv
// time_counter: 24-hour BCD timekeeping datapath.
// Divides CLK down to a 1 Hz tick and a 2 Hz blink wave, and holds the
// BCD seconds/minutes/hours, which the SECCLR/MININC/HOURINC levels adjust.
// Optional feature macro DAYCARRY_EN adds DAYUP, a one-cycle pulse on a
// carry-driven 23:59:59 -> 00:00:00 day wrap.
module time_counter #(
    parameter int DIV1HZ = 50000000,
    parameter int CW     = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SECCLR,
    input  logic       MININC,
    input  logic       HOURINC,
    output logic       SIG2HZ,
    output logic [7:0] SEC,
    output logic [7:0] MIN,
`ifdef DAYCARRY_EN
    output logic [7:0] HOUR,
    output logic       DAYUP
`else
    output logic [7:0] HOUR
`endif
);

    localparam logic [CW-1:0] LAST = CW'(DIV1HZ - 1);
    localparam logic [CW-1:0] Q1   = CW'(DIV1HZ / 4);
    localparam logic [CW-1:0] HALF = CW'(DIV1HZ / 2);
    localparam logic [CW-1:0] Q3   = CW'(3 * (DIV1HZ / 4));

    // Increment a two-digit BCD value, wrapping to 00 after 'last'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        logic [7:0] r;
        if (v == last)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [CW-1:0] pcnt;
    logic          tick;
    logic          blink;
    logic          sec_carry;
    logic          min_up;
    logic          min_carry;
    logic          hour_up;

    // SECCLR suppresses the tick so a clear never leaks a carry into minutes.
    assign tick      = (pcnt == LAST) && !SECCLR;
    assign blink     = (pcnt < Q1) || ((pcnt >= HALF) && (pcnt < Q3));
    assign sec_carry = tick && (SEC == 8'h59);
    assign min_up    = MININC | sec_carry;
    assign min_carry = sec_carry && (MIN == 8'h59);
    assign hour_up   = HOURINC | min_carry;

    // Prescaler and blink wave; a prescaler restart also restarts the blink high.
    always_ff @(posedge CLK) begin
        if (!RST || SECCLR) begin
            pcnt   <= '0;
            SIG2HZ <= 1'b1;
        end else begin
            pcnt   <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
            SIG2HZ <= blink;
        end
    end

    // Seconds: clear has priority over the tick.
    always_ff @(posedge CLK) begin
        if (!RST || SECCLR)
            SEC <= 8'h00;
        else if (tick)
            SEC <= bcd_inc(SEC, 8'h59);
    end

    // Minutes: request and carry OR together so a coincidence counts once.
    always_ff @(posedge CLK) begin
        if (!RST)
            MIN <= 8'h00;
        else if (min_up)
            MIN <= bcd_inc(MIN, 8'h59);
    end

    // Hours: 00-23, no further carry out.
    always_ff @(posedge CLK) begin
        if (!RST)
            HOUR <= 8'h00;
        else if (hour_up)
            HOUR <= bcd_inc(HOUR, 8'h23);
    end

`ifdef DAYCARRY_EN
    // Day pulse only when the 23->00 wrap comes through the minute carry.
    always_ff @(posedge CLK) begin
        if (!RST)
            DAYUP <= 1'b0;
        else
            DAYUP <= min_carry && (HOUR == 8'h23);
    end
`endif

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Timekeeping datapath for the 24-hour clock.
- Divides the system clock into a 1 Hz count enable and the 2 Hz blink square wave (SIG2HZ) that feeds the mode/adjust state machine.
- Holds BCD seconds, minutes and hours, and applies the adjust pulses SECCLR, MININC and HOURINC that the state machine drives.
- Outputs feed the 7-segment display driver.

Parameters:
- DIV1HZ, 50000000: system clock cycles per second. Must be a multiple of 4 and at least 8.
- CW, 26: prescaler counter width. Must satisfy 2^CW > DIV1HZ-1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset.
- SECCLR  in  1  clear seconds. Level, sampled every cycle.
- MININC  in  1  minute increment request. Level, sampled every cycle.
- HOURINC  in  1  hour increment request. Level, sampled every cycle.
- SIG2HZ  out  1  2 Hz square wave, 50% duty.
- SEC  out  8  seconds, BCD: [7:4] tens 0-5, [3:0] ones 0-9.
- MIN  out  8  minutes, BCD: [7:4] tens 0-5, [3:0] ones 0-9.
- HOUR  out  8  hours, BCD: [7:4] tens 0-2, [3:0] ones 0-9, value 00-23.

Behaviour:
- Reset: any cycle with RST==0 sets the prescaler to 0, SEC=MIN=HOUR=8'h00 and SIG2HZ=1. Applies mid-count with no partial updates. Reset overrides every other input.
- Prescaler:
  - pcnt counts 0..DIV1HZ-1 and wraps to 0.
  - Internal tick is asserted for exactly one cycle, when pcnt==DIV1HZ-1.
- SIG2HZ: registered, one cycle latency from pcnt.
  - 1 while pcnt is in [0, DIV1HZ/4) or [DIV1HZ/2, 3*DIV1HZ/4); 0 otherwise.
  - A pcnt reset (by RST or SECCLR) restarts the blink phase high.
- Seconds:
  - SECCLR==1: SEC<=00 and pcnt<=0, regardless of tick. No carry into minutes. SIG2HZ stays 1 while SECCLR is held.
  - Otherwise on tick: SEC+1 in BCD (ones 9 wraps to 0 with tens+1). 59 wraps to 00 and generates sec_carry for that same cycle.
- Minutes:
  - min_up = MININC | sec_carry.
  - When both are high in one cycle, increment exactly once, never by 2.
  - 59 wraps to 00. min_carry is generated only when the wrap is caused by sec_carry, not by MININC alone.
- Hours:
  - hour_up = HOURINC | min_carry, again a single increment.
  - 09->10, 19->20, 23->00. No further carry.
- Level inputs: a level held for N cycles produces N increments. Debounce and one-shot shaping happen upstream.
- Arithmetic: BCD only, never binary-then-convert. Illegal BCD values are unreachable from reset.
- Latency: SEC, MIN and HOUR update on the same clock edge as the triggering tick or request. All outputs are registered.
- Full rollover: 23:59:59 plus tick gives 00:00:00 in a single edge.

Optional Feature:
- Macro DAYCARRY_EN.
- When defined: adds output port DAYUP (out, 1). DAYUP pulses high for exactly one cycle on the edge where HOUR wraps 23->00 through the min_carry path. It stays 0 when the wrap comes from HOURINC alone, and resets to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- DIV1HZ=8, RST low 2 cycles then high -> SEC/MIN/HOUR=00/00/00, SIG2HZ=1. After 8 cycles SEC=01. After 80 cycles SEC=10.
- Preload 00:00:59 by MININC/HOURINC=0 and ticking, then one more tick -> SEC=00, MIN=01 on the same edge. SIG2HZ pattern 1,1,0,0,1,1,0,0 per 8 cycles.
- Reach 23:59:59, tick -> 00:00:00. With DAYCARRY_EN: DAYUP=1 for one cycle only. HOUR=23 then HOURINC 1 cycle -> HOUR=00, DAYUP stays 0.
- SEC=00:00:59 and MININC high on the tick edge -> MIN increments by 1 (00->01), not 2. HOURINC held 25 cycles from 00 -> HOUR=01.
- SECCLR asserted at pcnt=5, SEC=37 -> next edge SEC=00, MIN unchanged, pcnt=0. Next tick arrives 8 cycles after SECCLR deasserts.
- RST low mid-count at 12:34:56 -> next edge all zero, SIG2HZ=1. Counting resumes from pcnt=0.
